reg_file_32x32: RTL

REG_FILE_32X32 -- requirements
Module: reg_file_32x32

---
 rtl/regfile_pkg.sv | 12 +
 rtl/reg_wr_decode.sv | 15 +
 rtl/reg_file_32x32.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file.
// Holds the address width, register count, the hard-wired zero address and the address type.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : regfile_pkg

// File: rtl/reg_wr_decode.sv
// Write-address decoder: 5-bit register address to a 32-bit one-hot select.
// Ports: addr (in, 5b) -> sel (out, 32b one-hot). Purely combinational.
module reg_wr_decode
    import regfile_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [NUM_REGS-1:0]   sel
);

    always_comb begin
        sel       = '0;
        sel[addr] = 1'b1;
    end

endmodule : reg_wr_decode

// File: rtl/reg_file_32x32.sv
// 32 x DATA_W register file, one write port, two registered read ports, r0 hard-wired to 0.
// Ports: clk, reset (sync, active-low), RegWrite/WriteReg/WriteData (write),
//        ReadReg1/ReadReg2 (read addresses), ReadData1/ReadData2 (data, 1-cycle latency).
// Build option: define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module reg_file_32x32
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0] ReadReg1,
    input  logic [REG_ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0]     ReadData1,
    output logic [DATA_W-1:0]     ReadData2
);

    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] wr_en;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] rd2_d;

    reg_wr_decode u_wr_decode (
        .addr (WriteReg),
        .sel  (wr_sel)
    );

    assign wr_en = wr_sel & {NUM_REGS{RegWrite}};

    // Entry 0 is forced to zero so it synthesises away and always reads 0.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
        end
        regs_d[ZERO_REG] = '0;
    end

    always_comb begin
        rd1_d = regs_q[ReadReg1];
        rd2_d = regs_q[ReadReg2];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write; address 0 is never forwarded.
        if (RegWrite && (WriteReg == ReadReg1) && (ReadReg1 != ZERO_REG)) begin
            rd1_d = WriteData;
        end
        if (RegWrite && (WriteReg == ReadReg2) && (ReadReg2 != ZERO_REG)) begin
            rd2_d = WriteData;
        end
`endif
    end

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;

endmodule : reg_file_32x32
